captura_lectura: RTL and testbench
==================================

CAPTURA_LECTURA -- requirements
Module: captura_lectura

Interface
REQ-001 The module SHALL have one parameter: TIMEOUT, default 31, maximum number of clk cycles permitted in states ESPERA plus LEE for one byte, range 1..31.
REQ-002 Port: clk  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low reset.
REQ-004 Port: en  in  1  active-low enable; en=1 SHALL force the FSM to IDLE and hold all data registers.
REQ-005 Port: cs_n  in  1  RTC chip select, active-low; a transaction exists only while cs_n=0.
REQ-006 Port: ad_n  in  1  bus phase; 0 = address phase, 1 = data phase.
REQ-007 Port: rd_n  in  1  read strobe, active-low; the RTC drives dato_bus while rd_n=0.
REQ-008 Port: dato_bus  in  8  multiplexed address/data bus, synchronous to clk.
REQ-009 Ports: seg, min, hora, dia, mes, anio, t_seg, t_min, t_hora  out  8 each  captured RTC registers.
REQ-010 Port: byte_ok  out  1  one-cycle pulse per stored byte.
REQ-011 Port: trama_lista  out  1  one-cycle pulse when all nine registers have been captured in the current frame.
REQ-012 Port: error_dir  out  1  sticky flag for an unknown address or a timeout.

Function
REQ-013 The address map SHALL be: 0x21 seg, 0x22 min, 0x23 hora, 0x24 dia, 0x25 mes, 0x26 anio, 0x41 t_seg, 0x42 t_min, 0x43 t_hora; every other address is invalid.
REQ-014 The FSM SHALL have the states IDLE, DIR, ESPERA, LEE, ESCRIBE and FIN.
REQ-015 IDLE->DIR SHALL occur when cs_n=0 and ad_n=0; in DIR the internal register dir SHALL load dato_bus every cycle.
REQ-016 DIR->ESPERA SHALL occur when ad_n=1; the last value sampled with ad_n=0 is the address; the timeout counter SHALL clear on entry.
REQ-017 ESPERA->LEE SHALL occur when rd_n=0; in LEE the internal register dato SHALL load dato_bus every cycle while rd_n=0.
REQ-018 LEE->ESCRIBE SHALL occur when rd_n=1; the stored byte is the last value sampled with rd_n=0.
REQ-019 ESCRIBE SHALL last exactly one cycle. With a valid dir it SHALL write dato to the mapped register, pulse byte_ok and set that register's mask bit. With an invalid dir it SHALL set error_dir and write nothing. It then SHALL go to FIN.
REQ-020 FIN->IDLE SHALL occur when cs_n=1; no further capture SHALL occur until cs_n deasserts.
REQ-021 cs_n=1 in DIR, ESPERA or LEE SHALL abort to IDLE with no write, no byte_ok and no error.
REQ-022 The timeout counter SHALL increment each cycle in ESPERA and LEE. On reaching TIMEOUT the FSM SHALL go to FIN, set error_dir and write nothing.
REQ-023 The 9-bit capture mask SHALL record the registers written since the last frame completion. When the mask becomes all ones, trama_lista SHALL pulse in the cycle after the byte_ok that completed it, and the mask SHALL clear in the same cycle.
REQ-024 A repeated write to an already-captured address SHALL update the register, pulse byte_ok and leave the mask unchanged.
REQ-025 error_dir SHALL clear on the IDLE->DIR transition of the next transaction; setting it and clearing it never coincide.
REQ-026 en=1 SHALL abort any transaction to IDLE, suppress byte_ok and trama_lista, and preserve the mask, error_dir and the data registers.
REQ-027 Byte latency: byte_ok SHALL assert exactly one cycle after the first clk edge that samples rd_n=1 in LEE.

Reset
REQ-028 reset=0 SHALL immediately force: FSM=IDLE; all nine data registers = 0x00; dir, dato and the mask = 0; timeout counter = 0; byte_ok, trama_lista, error_dir = 0.
REQ-029 Reset asserted mid-transaction SHALL discard the transaction with no partial write.
REQ-030 After reset release, the first capture SHALL require a fresh IDLE->DIR transition.

Verification
REQ-031 Addr 0x23 for 2 cycles, rd_n low 3 cycles with data 0x15 -> hora=0x15; byte_ok high one cycle, one cycle after rd_n rises; error_dir=0.
REQ-032 Nine transactions 0x21..0x26, 0x41..0x43 with data 0x01..0x09 -> each register holds its value; nine byte_ok pulses; one trama_lista pulse one cycle after the ninth byte_ok; mask cleared.
REQ-033 Addr 0x30 with data 0xAA -> no register changes, no byte_ok, error_dir=1; next cs_n=0/ad_n=0 -> error_dir=0.
REQ-034 TIMEOUT=4, addr 0x21, rd_n held high -> error_dir=1 after 4 cycles in ESPERA; seg unchanged; FSM waits in FIN until cs_n=1.
REQ-035 cs_n raised during LEE of addr 0x22 -> min unchanged, no byte_ok, FSM in IDLE on the next cycle.
REQ-036 reset pulsed low during LEE with seg=0x59 -> all outputs 0x00/0 immediately; a later full transaction writes normally.

Source files
------------

// File: rtl/captura_lectura.sv
// captura_lectura: captures RTC registers from a multiplexed address/data bus.
// Each transaction runs: address phase (ad_n=0), then a read strobe (rd_n=0),
// and stores the byte into one of nine registers.
// Frame completion, address errors and timeouts are reported on the status outputs.
module captura_lectura #(
  parameter int TIMEOUT = 31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       cs_n,
  input  logic       ad_n,
  input  logic       rd_n,
  input  logic [7:0] dato_bus,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic [7:0] t_seg,
  output logic [7:0] t_min,
  output logic [7:0] t_hora,
  output logic       byte_ok,
  output logic       trama_lista,
  output logic       error_dir
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DIR     = 3'd1,
    ESPERA  = 3'd2,
    LEE     = 3'd3,
    ESCRIBE = 3'd4,
    FIN     = 3'd5
  } state_t;

  // Last counter value at which the byte may still complete without timing out.
  localparam logic [4:0] TMO_LAST = 5'(TIMEOUT - 1);

  state_t     state;
  state_t     nxt;

  logic [7:0] dir;
  logic [7:0] dato;
  logic [4:0] cnt;
  logic [8:0] mask;
  logic [8:0] sel;
  logic [7:0] regs [9];

  logic       dir_ok;
  logic       tmo;
  logic       frame_done;
  logic       ld_dir;
  logic       ld_dato;
  logic       cnt_clr;
  logic       cnt_inc;
  logic       wr_en;
  logic       set_err;
  logic       clr_err;

  // Address decode: one-hot register select, all zeros for unmapped addresses.
  always_comb begin
    sel = '0;
    case (dir)
      8'h21:   sel = 9'b0_0000_0001;
      8'h22:   sel = 9'b0_0000_0010;
      8'h23:   sel = 9'b0_0000_0100;
      8'h24:   sel = 9'b0_0000_1000;
      8'h25:   sel = 9'b0_0001_0000;
      8'h26:   sel = 9'b0_0010_0000;
      8'h41:   sel = 9'b0_0100_0000;
      8'h42:   sel = 9'b0_1000_0000;
      8'h43:   sel = 9'b1_0000_0000;
      default: sel = '0;
    endcase
  end

  assign dir_ok     = |sel;
  assign tmo        = (cnt >= TMO_LAST);
  assign frame_done = (mask == '1) && !en;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state and datapath control.
  always_comb begin
    nxt     = state;
    ld_dir  = 1'b0;
    ld_dato = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    wr_en   = 1'b0;
    set_err = 1'b0;
    clr_err = 1'b0;
    if (en) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!cs_n && !ad_n) begin
            nxt     = DIR;
            ld_dir  = 1'b1;
            clr_err = 1'b1;
          end
        end
        DIR: begin
          if (cs_n) begin
            nxt = IDLE;
          end else if (ad_n) begin
            nxt     = ESPERA;
            cnt_clr = 1'b1;
          end else begin
            ld_dir = 1'b1;
          end
        end
        ESPERA: begin
          // A move to LEE on the last permitted cycle could never finish in time.
          if (cs_n) begin
            nxt = IDLE;
          end else if (tmo) begin
            nxt     = FIN;
            set_err = 1'b1;
          end else if (!rd_n) begin
            nxt     = LEE;
            ld_dato = 1'b1;
            cnt_inc = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        LEE: begin
          // Completing the read takes priority over the timeout on the same cycle.
          if (cs_n) begin
            nxt = IDLE;
          end else if (rd_n) begin
            nxt = ESCRIBE;
          end else if (tmo) begin
            nxt     = FIN;
            set_err = 1'b1;
          end else begin
            ld_dato = 1'b1;
            cnt_inc = 1'b1;
          end
        end
        ESCRIBE: begin
          nxt = FIN;
          if (dir_ok) wr_en   = 1'b1;
          else        set_err = 1'b1;
        end
        FIN: begin
          if (cs_n) nxt = IDLE;
        end
        default: nxt = IDLE;
      endcase
    end
  end

  // Address/data capture and timeout counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir  <= '0;
      dato <= '0;
      cnt  <= '0;
    end else begin
      if (ld_dir)  dir  <= dato_bus;
      if (ld_dato) dato <= dato_bus;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 5'd1;
    end
  end

  // Register file write, byte/frame pulses and capture mask.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 9; i++) regs[i] <= '0;
      mask        <= '0;
      byte_ok     <= 1'b0;
      trama_lista <= 1'b0;
    end else begin
      byte_ok     <= 1'b0;
      trama_lista <= 1'b0;
      if (wr_en) begin
        for (int unsigned i = 0; i < 9; i++) begin
          if (sel[i]) regs[i] <= dato;
        end
        byte_ok <= 1'b1;
        mask    <= mask | sel;
      end else if (frame_done) begin
        trama_lista <= 1'b1;
        mask        <= '0;
      end
    end
  end

  // Sticky error flag, cleared when the next transaction starts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       error_dir <= 1'b0;
    else if (clr_err) error_dir <= 1'b0;
    else if (set_err) error_dir <= 1'b1;
  end

  assign seg    = regs[0];
  assign min    = regs[1];
  assign hora   = regs[2];
  assign dia    = regs[3];
  assign mes    = regs[4];
  assign anio   = regs[5];
  assign t_seg  = regs[6];
  assign t_min  = regs[7];
  assign t_hora = regs[8];

endmodule

// File: tb/tb_captura_lectura.sv
// Directed bench for captura_lectura: a default-timeout instance plus a TIMEOUT=4 instance.
module tb_captura_lectura;

  logic       clk;
  logic       reset;
  logic       en;
  logic       cs_n;
  logic       cs_t;
  logic       ad_n;
  logic       rd_n;
  logic [7:0] dato_bus;

  logic [7:0] seg, min, hora, dia, mes, anio, t_seg, t_min, t_hora;
  logic       byte_ok, trama_lista, error_dir;
  logic [7:0] seg_t, min_t, hora_t, dia_t, mes_t, anio_t, t_seg_t, t_min_t, t_hora_t;
  logic       byte_ok_t, trama_lista_t, error_dir_t;

  int total = 0;
  int bad   = 0;
  logic e;

  logic [7:0] addrs  [9]  = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
  logic [7:0] addrs2 [10] = '{8'h21, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

  captura_lectura dut (
    .clk(clk), .reset(reset), .en(en), .cs_n(cs_n), .ad_n(ad_n), .rd_n(rd_n),
    .dato_bus(dato_bus), .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes),
    .anio(anio), .t_seg(t_seg), .t_min(t_min), .t_hora(t_hora),
    .byte_ok(byte_ok), .trama_lista(trama_lista), .error_dir(error_dir)
  );

  captura_lectura #(.TIMEOUT(4)) dut_t (
    .clk(clk), .reset(reset), .en(en), .cs_n(cs_t), .ad_n(ad_n), .rd_n(rd_n),
    .dato_bus(dato_bus), .seg(seg_t), .min(min_t), .hora(hora_t), .dia(dia_t), .mes(mes_t),
    .anio(anio_t), .t_seg(t_seg_t), .t_min(t_min_t), .t_hora(t_hora_t),
    .byte_ok(byte_ok_t), .trama_lista(trama_lista_t), .error_dir(error_dir_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] reg_of(input int k);
    case (k)
      0: return seg;
      1: return min;
      2: return hora;
      3: return dia;
      4: return mes;
      5: return anio;
      6: return t_seg;
      7: return t_min;
      default: return t_hora;
    endcase
  endfunction

  // Full transaction on the default instance; returns byte_ok one edge early.
  task automatic txn(input logic [7:0] a, input logic [7:0] d, input int na, input int nr,
                     output logic early);
    cs_n = 1'b0; ad_n = 1'b0; dato_bus = a;
    repeat (na) tick;
    ad_n = 1'b1; dato_bus = 8'h00;
    tick;
    rd_n = 1'b0; dato_bus = d;
    repeat (nr) tick;
    rd_n = 1'b1; dato_bus = 8'hFF;
    tick;
    early = byte_ok;
    tick;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; cs_n = 1'b1; cs_t = 1'b1;
    ad_n = 1'b1; rd_n = 1'b1; dato_bus = 8'h00;
    tick; tick;
    for (int k = 0; k < 9; k++) chk("rst_reg", 32'(reg_of(k)), 32'h0);
    chk("rst_byte_ok", 32'(byte_ok), 32'h0);
    chk("rst_trama", 32'(trama_lista), 32'h0);
    chk("rst_err", 32'(error_dir), 32'h0);
    chk("rst_state", 32'(3'(dut.state)), 32'h0);
    reset = 1'b1;
    tick;

    // No capture without an address phase after reset
    cs_n = 1'b0; ad_n = 1'b1;
    tick;
    chk("fresh_idle", 32'(3'(dut.state)), 32'h0);
    cs_n = 1'b1;
    tick;

    // Timeout on the TIMEOUT=4 instance
    cs_t = 1'b0; ad_n = 1'b0; dato_bus = 8'h21;
    tick;
    ad_n = 1'b1; dato_bus = 8'h00;
    tick;
    repeat (3) tick;
    chk("tmo_early", 32'(error_dir_t), 32'h0);
    tick;
    chk("tmo_err", 32'(error_dir_t), 32'h1);
    chk("tmo_fin", 32'(3'(dut_t.state)), 32'h5);
    chk("tmo_seg", 32'(seg_t), 32'h0);
    rd_n = 1'b0; dato_bus = 8'h99;
    tick; tick;
    rd_n = 1'b1;
    tick; tick;
    chk("tmo_hold_seg", 32'(seg_t), 32'h0);
    chk("tmo_hold_ok", 32'(byte_ok_t), 32'h0);
    chk("tmo_hold_fin", 32'(3'(dut_t.state)), 32'h5);
    cs_t = 1'b1;
    tick;
    chk("tmo_idle", 32'(3'(dut_t.state)), 32'h0);
    chk("tmo_sticky", 32'(error_dir_t), 32'h1);

    // Single byte: address 2 cycles, read 3 cycles
    txn(8'h23, 8'h15, 2, 3, e);
    chk("lat_early", 32'(e), 32'h0);
    chk("lat_ok", 32'(byte_ok), 32'h1);
    chk("hora", 32'(hora), 32'h15);
    chk("one_err", 32'(error_dir), 32'h0);
    cs_n = 1'b1;
    tick;
    chk("ok_one_cycle", 32'(byte_ok), 32'h0);
    chk("one_trama", 32'(trama_lista), 32'h0);

    // Full frame
    for (int i = 0; i < 9; i++) begin
      txn(addrs[i], 8'(i + 1), 1, 1, e);
      chk("frame_ok", 32'(byte_ok), 32'h1);
      cs_n = 1'b1;
      tick;
      chk("frame_trama", 32'(trama_lista), (i == 8) ? 32'h1 : 32'h0);
    end
    tick;
    chk("frame_trama_end", 32'(trama_lista), 32'h0);
    for (int k = 0; k < 9; k++) chk("frame_reg", 32'(reg_of(k)), 32'(k + 1));

    // Second frame with a repeated address; mask must have been cleared
    for (int j = 0; j < 10; j++) begin
      txn(addrs2[j], 8'(8'h10 + j), 1, 1, e);
      chk("frame2_ok", 32'(byte_ok), 32'h1);
      cs_n = 1'b1;
      tick;
      chk("frame2_trama", 32'(trama_lista), (j == 9) ? 32'h1 : 32'h0);
    end
    for (int k = 0; k < 9; k++) chk("frame2_reg", 32'(reg_of(k)), 32'(8'h11 + k));

    // Unknown address
    txn(8'h30, 8'hAA, 1, 1, e);
    chk("bad_ok", 32'(byte_ok), 32'h0);
    chk("bad_err", 32'(error_dir), 32'h1);
    cs_n = 1'b1;
    tick;
    chk("bad_trama", 32'(trama_lista), 32'h0);
    for (int k = 0; k < 9; k++) chk("bad_reg", 32'(reg_of(k)), 32'(8'h11 + k));

    // en=1 blocks new transactions and keeps the error flag
    en = 1'b1; cs_n = 1'b0; ad_n = 1'b0; dato_bus = 8'h21;
    tick; tick;
    chk("en_err_kept", 32'(error_dir), 32'h1);
    chk("en_idle", 32'(3'(dut.state)), 32'h0);
    en = 1'b0; cs_n = 1'b1; ad_n = 1'b1;
    tick;
    cs_n = 1'b0; ad_n = 1'b0;
    tick;
    chk("err_clear", 32'(error_dir), 32'h0);
    chk("err_clear_dir", 32'(3'(dut.state)), 32'h1);
    cs_n = 1'b1; ad_n = 1'b1;
    tick;
    chk("dir_abort", 32'(3'(dut.state)), 32'h0);

    // en=1 during LEE aborts without a write
    cs_n = 1'b0; ad_n = 1'b0; dato_bus = 8'h25;
    tick;
    ad_n = 1'b1;
    tick;
    rd_n = 1'b0; dato_bus = 8'h66;
    tick;
    en = 1'b1;
    tick;
    chk("en_abort_idle", 32'(3'(dut.state)), 32'h0);
    rd_n = 1'b1;
    tick;
    chk("en_abort_ok", 32'(byte_ok), 32'h0);
    en = 1'b0; cs_n = 1'b1;
    tick;
    chk("en_abort_ok2", 32'(byte_ok), 32'h0);
    chk("en_abort_mes", 32'(mes), 32'h15);

    // cs_n raised during LEE
    cs_n = 1'b0; ad_n = 1'b0; dato_bus = 8'h22;
    tick;
    ad_n = 1'b1;
    tick;
    rd_n = 1'b0; dato_bus = 8'h77;
    tick; tick;
    cs_n = 1'b1;
    tick;
    chk("cs_abort_idle", 32'(3'(dut.state)), 32'h0);
    chk("cs_abort_ok", 32'(byte_ok), 32'h0);
    rd_n = 1'b1;
    tick;
    chk("cs_abort_ok2", 32'(byte_ok), 32'h0);
    chk("cs_abort_min", 32'(min), 32'h12);
    chk("cs_abort_err", 32'(error_dir), 32'h0);

    // Reset during LEE
    txn(8'h21, 8'h59, 1, 1, e);
    cs_n = 1'b1;
    tick;
    chk("pre_rst_seg", 32'(seg), 32'h59);
    cs_n = 1'b0; ad_n = 1'b0; dato_bus = 8'h22;
    tick;
    ad_n = 1'b1;
    tick;
    rd_n = 1'b0; dato_bus = 8'h33;
    tick; tick;
    #2 reset = 1'b0;
    #1;
    for (int k = 0; k < 9; k++) chk("async_rst_reg", 32'(reg_of(k)), 32'h0);
    chk("async_rst_ok", 32'(byte_ok), 32'h0);
    chk("async_rst_err", 32'(error_dir), 32'h0);
    chk("async_rst_state", 32'(3'(dut.state)), 32'h0);
    tick;
    reset = 1'b1; rd_n = 1'b1;
    tick; tick;
    chk("post_rst_ok", 32'(byte_ok), 32'h0);
    chk("post_rst_min", 32'(min), 32'h0);
    chk("post_rst_idle", 32'(3'(dut.state)), 32'h0);
    cs_n = 1'b1;
    tick;
    txn(8'h24, 8'h5A, 1, 1, e);
    chk("post_rst_wr_ok", 32'(byte_ok), 32'h1);
    chk("post_rst_dia", 32'(dia), 32'h5A);
    chk("post_rst_seg", 32'(seg), 32'h0);
    cs_n = 1'b1;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
